// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_state_t : responder FSM states
//   cnt_t        : wait-state counter, wide enough for MAX_LATENCY
//   addr_legal() : word-aligned and inside the array
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // Upper address bits are compared against DEPTH rather than dropped,
  // so an address past the end of the array reports an error instead of
  // aliasing onto a low word.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input int unsigned depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM with synchronous write and synchronous (registered) read.
// Ports:
//   clk, reset : clock and asynchronous active-low reset (read register only)
//   we, re     : write / read strobes for this edge
//   idx        : word index
//   wdata      : write data
//   rdata      : registered read data, held until the next read
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage itself has no reset so it can map onto a RAM macro;
  // only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: captures a load/store request, waits LATENCY
// cycles, performs the access and returns a one-cycle ack with read data.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   req, we           : request strobe (sampled in IDLE), write enable
//   addr, wdata       : byte address, write data
//   rdata             : read data, held until the next read response
//   ack, err          : one-cycle response pulse, error flag valid with ack
//   busy              : high whenever the FSM is not IDLE
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dmem_responder: DEPTH must be a power of two in 4..1024");
  end
  if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("dmem_responder: LATENCY out of range 0..15");
  end

  dmem_state_t state;
  cnt_t        cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  // The access happens on the edge that enters RESP. With LATENCY=0 that
  // is the capturing edge itself, so the live inputs are used; otherwise
  // the captured copies are.
  logic        go_resp;
  logic        acc_we;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_legal;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    go_resp   = 1'b0;
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    unique case (state)
      IDLE: begin
        if (req && LATENCY == 0) begin
          go_resp   = 1'b1;
          acc_we    = we;
          acc_addr  = addr;
          acc_wdata = wdata;
        end
      end
      WAIT:    go_resp = (cnt == '0);
      default: go_resp = 1'b0;
    endcase
  end

  assign acc_legal = addr_legal(acc_addr, DEPTH);

  // Gated by reset so an edge that arrives while reset is held cannot
  // commit a write through the LATENCY=0 path.
  logic mem_we;
  logic mem_re;
  assign mem_we = reset && go_resp && acc_legal &&  acc_we;
  assign mem_re = reset && go_resp && acc_legal && !acc_we;

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            cap_we    <= we;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            busy      <= 1'b1;
            if (LATENCY == 0) begin
              state <= RESP;
              ack   <= 1'b1;
              err   <= !acc_legal;
            end else begin
              state <= WAIT;
              cnt   <= cnt_t'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
            ack   <= 1'b1;
            err   <= !acc_legal;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
